// File: rtl/alu_pipe_pkg.sv
// Shared types for the alu_pipe block: operation codes and FSM state encoding.
// The BUSY state exists only when ALU_PIPE_MUL_EN is defined.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_OR  = 4'd0,
    ALU_AND = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_MUL = 4'd8
  } op_code;

  typedef logic [1:0] alu_state_t;

  localparam alu_state_t ST_IDLE = 2'd0;
`ifdef ALU_PIPE_MUL_EN
  localparam alu_state_t ST_BUSY = 2'd1;
`endif
  localparam alu_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier for alu_pipe: one partial product per cycle,
// WIDTH iterations, low WIDTH bits of the product. start loads the operands;
// done pulses combinationally during the last iteration with prod valid.
// Built only when ALU_PIPE_MUL_EN is defined.
`ifdef ALU_PIPE_MUL_EN
module alu_pipe_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0] mcand_p1;
  logic [WIDTH-1:0] mplier_p1;
  logic [WIDTH-1:0] acc_nxt;

  assign acc_nxt = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
  assign done    = busy_p1 && (cnt_p1 == CNT_W'(WIDTH - 1));
  assign prod    = acc_nxt;

  // Control and accumulator: load on start, then one iteration per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_p1 <= 1'b0;
      cnt_p1  <= '0;
      acc_p1  <= '0;
    end else if (start) begin
      busy_p1 <= 1'b1;
      cnt_p1  <= '0;
      acc_p1  <= '0;
    end else if (busy_p1) begin
      acc_p1 <= acc_nxt;
      cnt_p1 <= cnt_p1 + 1'b1;
      if (done) busy_p1 <= 1'b0;
    end
  end

  // Operand shifters; their contents only matter while busy.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p1  <= a;
      mplier_p1 <= b;
    end else if (busy_p1) begin
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

endmodule
`endif

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result. Single-cycle ops finish
// one cycle after acceptance; MUL (only with ALU_PIPE_MUL_EN defined) runs
// WIDTH cycles in an iterative multiplier. Without the macro MUL is illegal.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  op_code           op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             illegal_o
);

  alu_state_t              state_p1;
  logic [WIDTH-1:0]        res_p1;
  logic                    ovf_p1;
  logic                    ill_p1;

  logic signed [WIDTH-1:0] rs_s;
  logic signed [WIDTH-1:0] rt_s;
  logic [WIDTH-1:0]        sum;
  logic [WIDTH-1:0]        dif;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ovf;
  logic                    alu_ill;
  logic                    accept;

  // Two's complement overflow: equal operand signs, result sign differs.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign rs_s    = rs_i;
  assign rt_s    = rt_i;
  assign sum     = rs_i + rt_i;
  assign dif     = rs_i - rt_i;

  assign ready_o   = (state_p1 == ST_IDLE) || ((state_p1 == ST_DONE) && ready_i);
  assign accept    = valid_i && ready_o;
  assign valid_o   = (state_p1 == ST_DONE);
  assign result_o  = res_p1;
  assign zero_o    = (res_p1 == '0);
  assign ovf_o     = ovf_p1;
  assign illegal_o = ill_p1;

  // Single-cycle datapath; unknown op codes give zero with the illegal flag.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op_i)
      ALU_OR:  alu_res = rs_i | rt_i;
      ALU_AND: alu_res = rs_i & rt_i;
      ALU_XOR: alu_res = rs_i ^ rt_i;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf(rs_i[WIDTH-1], rt_i[WIDTH-1], sum[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = dif;
        alu_ovf = add_ovf(rs_i[WIDTH-1], ~rt_i[WIDTH-1], dif[WIDTH-1]);
      end
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, (rs_s < rt_s)};
      ALU_SLL: alu_res = rs_i << rt_i[SHAMT_W-1:0];
      ALU_SRL: alu_res = rs_i >> rt_i[SHAMT_W-1:0];
`ifdef ALU_PIPE_MUL_EN
      ALU_MUL: alu_res = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign mul_start = accept && (op_i == ALU_MUL);

  alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (mul_start),
    .a     (rs_i),
    .b     (rt_i),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`endif

  // ---- stage p1: FSM and registered result ----
  // A new request always wins; otherwise BUSY waits for the multiplier and
  // DONE drains to IDLE once the consumer takes the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p1 <= ST_IDLE;
      res_p1   <= '0;
      ovf_p1   <= 1'b0;
      ill_p1   <= 1'b0;
    end else if (accept) begin
`ifdef ALU_PIPE_MUL_EN
      if (op_i == ALU_MUL) begin
        state_p1 <= ST_BUSY;
      end else
`endif
      begin
        state_p1 <= ST_DONE;
        res_p1   <= alu_res;
        ovf_p1   <= alu_ovf;
        ill_p1   <= alu_ill;
      end
`ifdef ALU_PIPE_MUL_EN
    end else if (state_p1 == ST_BUSY) begin
      if (mul_done) begin
        state_p1 <= ST_DONE;
        res_p1   <= mul_prod;
        ovf_p1   <= 1'b0;
        ill_p1   <= 1'b0;
      end
`endif
    end else if ((state_p1 == ST_DONE) && ready_i) begin
      state_p1 <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=32). Stimulus pushes expected results into a
// scoreboard queue; a monitor pops and compares on every output handshake.
// MUL-specific timing is exercised when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  op_code      op_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        ovf_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  alu_pipe dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .rs_i      (rs_i),
    .rt_i      (rt_i),
    .op_i      (op_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .ovf_o     (ovf_o),
    .illegal_o (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per output handshake.
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result %h with no outstanding request (t=%0t)", result_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_word("sb_result", result_o, e.res);
        chk_bit("sb_zero", zero_o, e.zero);
        chk_bit("sb_ovf", ovf_o, e.ovf);
        chk_bit("sb_illegal", illegal_o, e.ill);
      end
    end
  end

  task automatic push_exp(input logic [31:0] res, input logic ovf, input logic ill);
    exp_t e;
    e.res  = res;
    e.zero = (res == 32'd0);
    e.ovf  = ovf;
    e.ill  = ill;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input op_code op, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    op_i    = op;
    rs_i    = a;
    rt_i    = b;
    @(negedge clk);
    chk_bit("ready_at_issue", ready_o, 1'b1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic single(input string name, input op_code op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res,
                        input logic ovf, input logic ill);
    push_exp(res, ovf, ill);
    send(op, a, b);
    @(negedge clk);
    chk_bit({name, "_lat1_valid"}, valid_o, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] bad_op;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = ALU_OR;
    rs_i    = '0;
    rt_i    = '0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_bit("rst_valid", valid_o, 1'b0);
    chk_word("rst_result", result_o, 32'h0);
    chk_bit("rst_zero", zero_o, 1'b1);
    chk_bit("rst_ovf", ovf_o, 1'b0);
    chk_bit("rst_illegal", illegal_o, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk_bit("ready_after_rst", ready_o, 1'b1);
    @(posedge clk);
    #1;

    single("add_ovf",   ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0);
    single("sub_zero",  ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0);
    single("slt_neg",   ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    single("slt_pos",   ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    single("add_wrap",  ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    single("sub_ovf",   ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0);
    single("or",        ALU_OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
    single("and",       ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0);
    single("xor_noovf", ALU_XOR, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFE, 1'b0, 1'b0);
    single("sll",       ALU_SLL, 32'h0000_0003, 32'h0000_0004, 32'h0000_0030, 1'b0, 1'b0);
    single("srl_mask",  ALU_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0);
    bad_op = 4'hF;
    single("illegal_f", op_code'(bad_op), 32'h1234_5678, 32'h1, 32'h0, 1'b0, 1'b1);
    bad_op = 4'h9;
    single("illegal_9", op_code'(bad_op), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);

    // Backpressure: result held for 4 cycles, then back-to-back SLL.
    ready_i = 1'b0;
    push_exp(32'h0000_0007, 1'b0, 1'b0);
    send(ALU_ADD, 32'h3, 32'h4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_bit("stall_valid", valid_o, 1'b1);
      chk_word("stall_result", result_o, 32'h0000_0007);
      chk_bit("stall_zero", zero_o, 1'b0);
      chk_bit("stall_ready", ready_o, 1'b0);
      @(posedge clk);
      #1;
      rs_i = $urandom;
      op_i = ALU_SUB;
    end
    ready_i = 1'b1;
    push_exp(32'h8000_0000, 1'b0, 1'b0);
    send(ALU_SLL, 32'h1, 32'd31);
    @(negedge clk);
    chk_bit("b2b_valid", valid_o, 1'b1);
    chk_word("b2b_result", result_o, 32'h8000_0000);
    @(posedge clk);
    #1;

    // Reset during a stalled DONE drops the pending result.
    ready_i = 1'b0;
    send(ALU_ADD, 32'h1, 32'h1);
    @(negedge clk);
    chk_bit("stall2_valid", valid_o, 1'b1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    chk_bit("rst_done_valid", valid_o, 1'b0);
    chk_word("rst_done_result", result_o, 32'h0);
    chk_bit("rst_done_ready", ready_o, 1'b1);
    @(posedge clk);
    #1;

`ifdef ALU_PIPE_MUL_EN
    // MUL: BUSY for 32 cycles with inputs ignored, valid on the 32nd.
    push_exp(32'h0005_000F, 1'b0, 1'b0);
    send(ALU_MUL, 32'h0001_0003, 32'h0000_0005);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk_bit("mul_busy_ready", ready_o, 1'b0);
      chk_bit("mul_busy_valid", valid_o, 1'b0);
      @(posedge clk);
      #1;
      valid_i = (i < 29);
      op_i    = ALU_ADD;
      rs_i    = $urandom;
      rt_i    = $urandom;
    end
    valid_i = 1'b0;
    @(negedge clk);
    chk_bit("mul_lat32_valid", valid_o, 1'b1);
    chk_word("mul_result", result_o, 32'h0005_000F);
    @(posedge clk);
    #1;

    // Reset at cycle 10 of a MUL: no result ever appears.
    send(ALU_MUL, 32'h0000_0007, 32'h0000_0009);
    repeat (9) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk_bit("rst_mul_valid", valid_o, 1'b0);
    chk_word("rst_mul_result", result_o, 32'h0);
    chk_bit("rst_mul_ready", ready_o, 1'b1);
    repeat (40) @(posedge clk);
    #1;
`else
    single("mul_illegal", ALU_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0, 1'b0, 1'b1);
`endif

    single("final_add", ALU_ADD, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_word("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), number of rt_i bits used as the shift amount.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  request valid.
REQ-006 SHALL have port ready_o  output  1  block can accept a request this cycle.
REQ-007 SHALL have port rs_i  input  WIDTH  operand A.
REQ-008 SHALL have port rt_i  input  WIDTH  operand B.
REQ-009 SHALL have port op_i  input  op_code  operation select (package type).
REQ-010 SHALL have port valid_o  output  1  result valid.
REQ-011 SHALL have port ready_i  input  1  consumer accepts the result.
REQ-012 SHALL have port result_o  output  WIDTH  registered result.
REQ-013 SHALL have port zero_o  output  1  result_o == 0.
REQ-014 SHALL have port ovf_o  output  1  signed overflow (ADD/SUB only).
REQ-015 SHALL have port illegal_o  output  1  op was unsupported; result_o = 0.

Function
REQ-016 SHALL accept a request on a rising edge where valid_i && ready_o; operands and op are captured then.
REQ-017 SHALL implement an FSM with states IDLE, BUSY, DONE; ready_o = (IDLE) || (DONE && ready_i).
REQ-018 SHALL, for single-cycle ops (OR, AND, XOR, ADD, SUB, SLT, SLL, SRL), go to DONE with valid_o high one cycle after acceptance.
REQ-019 SHALL compute SLT as signed rs_i < rt_i giving 1 or 0; SLL/SRL are logical shifts of rs_i by rt_i[SHAMT_W-1:0].
REQ-020 SHALL compute ADD/SUB modulo 2^WIDTH; ovf_o = signed overflow; ovf_o = 0 for all other ops.
REQ-021 SHALL, for MUL, enter BUSY and run a shift-add iteration per cycle for WIDTH cycles, then enter DONE; valid_o asserts WIDTH cycles after acceptance; result is low WIDTH bits of the product.
REQ-022 SHALL hold result_o, zero_o, ovf_o, illegal_o and valid_o stable in DONE until valid_o && ready_i.
REQ-023 SHALL, in DONE with ready_i high and a new valid_i, accept back-to-back (DONE->DONE or DONE->BUSY) with no bubble.
REQ-024 SHALL go DONE->IDLE on ready_i with no new request.
REQ-025 SHALL ignore valid_i while in BUSY (ready_o = 0); op_i/rs_i/rt_i changes there have no effect.
REQ-026 SHALL treat any op_code not listed as illegal: one-cycle latency, result_o = 0, zero_o = 1, illegal_o = 1.

Reset
REQ-027 SHALL, with rst_i high at a rising edge, enter IDLE and clear result_o, ovf_o, illegal_o, valid_o, iteration counter and MUL accumulator; zero_o = 1.
REQ-028 SHALL let reset override any state, including mid-MUL in BUSY and a stalled DONE; the aborted request produces no result.
REQ-029 SHALL drive ready_o = 1 on the first cycle after reset deasserts.

Configuration
REQ-030 SHALL compile the MUL datapath and BUSY state only when macro ALU_PIPE_MUL_EN is defined.
REQ-031 SHALL, without ALU_PIPE_MUL_EN, treat MUL as illegal per REQ-026; no BUSY state exists, and ready_o never deasserts except in stalled DONE.

Structure
REQ-032 SHALL take op_code (extended with ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_MUL) and the FSM state typedef from the shared package definitions.
REQ-033 SHALL place the iterative multiplier in one sub-module alu_pipe_mul (start/done pulse interface, WIDTH parameter).

Verification (WIDTH=32)
REQ-034 SHALL cover ADD 0x7FFFFFFF+1 -> result_o 0x80000000, ovf_o 1, valid_o one cycle after acceptance.
REQ-035 SHALL cover SUB 5-5 -> result_o 0, zero_o 1, ovf_o 0; SLT 0xFFFFFFFF vs 1 -> result_o 1.
REQ-036 SHALL cover MUL 0x00010003*0x00000005 -> result_o 0x0005000F, valid_o exactly 32 cycles after acceptance, ready_o low throughout BUSY.
REQ-037 SHALL cover backpressure: ready_i low for 4 cycles in DONE -> outputs stable; then ready_i high with new valid_i (SLL 1 by 31) -> next cycle result_o 0x80000000, no bubble.
REQ-038 SHALL cover rst_i asserted at cycle 10 of a MUL -> IDLE, valid_o 0, result_o 0, ready_o 1 next cycle.
REQ-039 SHALL cover undefined op_code, and MUL built without ALU_PIPE_MUL_EN -> illegal_o 1, result_o 0, one-cycle latency.
